fib_index: RTL

//  Inverse of the Fibonacci generator. Given a value, finds the index n

---
 rtl/fib_index.sv | 110 +++++++++++
 1 files changed

// File: rtl/fib_index.sv
// Inverse Fibonacci search: walks F(k) upward from F(0)=1 until it meets or
// passes the latched target, reporting hit/floor index/overflow.
module fib_index #(
    parameter int WIDTH = 10,
    parameter int NW    = 4,
    parameter int MAX_N = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pause,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [NW-1:0]    n,
    output logic             hit,
    output logic             ovf
);
    localparam int AW = WIDTH + 1;
    localparam logic [NW-1:0] KMAX = NW'(MAX_N);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt, tgt_nxt;
    logic [AW-1:0]    a, a_nxt, b, b_nxt;
    logic [NW-1:0]    k, k_nxt, n_nxt;
    logic             done_nxt, hit_nxt, ovf_nxt;
    logic [AW-1:0]    tgt_ext;

    assign tgt_ext = {1'b0, tgt};
    assign busy    = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tgt   <= '0;
            a     <= '0;
            b     <= '0;
            k     <= '0;
            done  <= 1'b0;
            n     <= '0;
            hit   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            tgt   <= tgt_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            k     <= k_nxt;
            done  <= done_nxt;
            n     <= n_nxt;
            hit   <= hit_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // done is the only field that moves while paused: it always falls back to 0.
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        a_nxt     = a;
        b_nxt     = b;
        k_nxt     = k;
        done_nxt  = 1'b0;
        n_nxt     = n;
        hit_nxt   = hit;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (start && !pause) begin
                    state_nxt = RUN;
                    tgt_nxt   = value;
                    a_nxt     = AW'(1);
                    b_nxt     = AW'(1);
                    k_nxt     = '0;
                    n_nxt     = '0;
                    hit_nxt   = 1'b0;
                    ovf_nxt   = 1'b0;
                end
            end
            RUN: begin
                if (!pause) begin
                    if (a == tgt_ext) begin
                        n_nxt     = k;
                        hit_nxt   = 1'b1;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (a > tgt_ext) begin
                        n_nxt     = (k == '0) ? '0 : k - NW'(1);
                        hit_nxt   = 1'b0;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (k == KMAX) begin
                        n_nxt     = KMAX;
                        hit_nxt   = 1'b0;
                        ovf_nxt   = 1'b1;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        a_nxt = b;
                        b_nxt = a + b;
                        k_nxt = k + NW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
